// File: rtl/uart8_rx_controller_pkg.sv
// Shared definitions for the UART byte-receive controller.
//   rx_state_e      : controller state encoding (also exported on the debug port)
//   RECOVER_CYCLES  : cycles the receiver is held disabled after an error
//   ENTRY_W         : FIFO entry width, {last, data[7:0]}
//   CONSEC_W        : width of the consecutive-error counter (ERR_LIMIT <= 15)
//   sat_inc8        : saturating 8-bit increment used by err_count
package uart8_rx_controller_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_ARM     = 3'd1,
      ST_RUN     = 3'd2,
      ST_RECOVER = 3'd3,
      ST_FAULT   = 3'd4
   } rx_state_e;

   localparam int RECOVER_CYCLES = 2;
   localparam int ENTRY_W        = 9;
   localparam int CONSEC_W       = 4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart8_rx_fifo.sv
// Synchronous first-word-fall-through FIFO of {last, data} entries.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointers/count only)
//   push, din  : write request and entry
//   pop        : read request, ignored when empty
//   dout       : head entry, zero while empty
//   count      : occupancy, 0..DEPTH
//   empty      : no entries
//   drop       : push refused because the FIFO is full and not popping
// A push and pop in the same cycle is accepted even when full.
module uart8_rx_fifo
   import uart8_rx_controller_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [ENTRY_W-1:0]       din,
   input  logic                     pop,
   output logic [ENTRY_W-1:0]       dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               full;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/uart8_rx_controller.sv
// Control layer around a 16x-oversampling UART receiver: enables the
// receiver, captures each completed byte once, counts and recovers from
// receive errors, and streams bytes out through a FWFT FIFO.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   enable, clear        : run request; clear of fault/overflow/err_count
//   rx_busy, rx_done,
//   rx_err, rx_data      : receiver status and byte
//   rx_en                : receiver enable (ARM and RUN only)
//   m_valid, m_last,
//   m_data, m_ready      : byte stream; a beat transfers when m_valid and
//                          m_ready are both high at a clock edge, m_valid
//                          never depends on m_ready, and the head entry
//                          stays stable until it transfers
//   fifo_count           : FIFO occupancy
//   overflow, fault      : sticky overflow, FAULT state indicator
//   err_count            : saturating total of receive errors
//   state                : current controller state (debug)
// Build option UART_RX_CTRL_LAST_EN: bytes pass through a one-entry staging
// register so the last byte of a packet (closed by line silence or by
// shutting down) can be tagged with m_last.
module uart8_rx_controller
   import uart8_rx_controller_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int IDLE_TIMEOUT = 480,
   parameter int ERR_LIMIT    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          clear,
   input  logic                          rx_busy,
   input  logic                          rx_done,
   input  logic                          rx_err,
   input  logic [7:0]                    rx_data,
   output logic                          rx_en,
   output logic                          m_valid,
   output logic                          m_last,
   output logic [7:0]                    m_data,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          fault,
   output logic [7:0]                    err_count,
   output rx_state_e                     state
);

   rx_state_e             state_q;
   rx_state_e             state_d;
   logic                  done_q;
   logic                  err_q;
   logic                  done_edge;
   logic                  err_edge;
   logic                  in_run;
   logic                  capture;
   logic                  err_hit;
   logic [1:0]            rec_cnt;
   logic [CONSEC_W-1:0]   consec;

   logic                  fifo_push;
   logic [ENTRY_W-1:0]    fifo_din;
   logic [ENTRY_W-1:0]    fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_drop;

   // Status inputs are level signals; only their rising edges are events.
   assign done_edge = rx_done && !done_q;
   assign err_edge  = rx_err && !err_q;
   assign in_run    = (state_q == ST_RUN) && enable;
   // An error edge coinciding with a done edge discards the byte.
   assign capture   = in_run && done_edge && !err_edge;
   assign err_hit   = in_run && err_edge;

   always_comb begin
      state_d = state_q;
      rx_en   = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (enable) state_d = ST_ARM;
         end
         ST_ARM: begin
            rx_en   = 1'b1;
            state_d = enable ? ST_RUN : ST_OFF;
         end
         ST_RUN: begin
            rx_en = 1'b1;
            if (!enable)       state_d = ST_OFF;
            else if (err_edge) state_d = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (!enable) begin
               state_d = ST_OFF;
            end else if (rec_cnt == 2'(RECOVER_CYCLES - 1)) begin
               // consec already includes the error that brought us here.
               state_d = (consec >= CONSEC_W'(ERR_LIMIT)) ? ST_FAULT : ST_ARM;
            end
         end
         ST_FAULT: begin
            if (clear) state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_OFF;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rec_cnt   <= '0;
         consec    <= '0;
         err_count <= '0;
         overflow  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= rx_done;
         err_q   <= rx_err;
         rec_cnt <= (state_q == ST_RECOVER) ? rec_cnt + 2'd1 : 2'd0;

         if (state_q == ST_FAULT && clear) begin
            consec <= '0;
         end else if (err_hit) begin
            if (consec != '1) consec <= consec + 1'b1;
         end else if (capture) begin
            consec <= '0;
         end

         if (clear)        err_count <= '0;
         else if (err_hit) err_count <= sat_inc8(err_count);

         if (clear)          overflow <= 1'b0;
         else if (fifo_drop) overflow <= 1'b1;
      end
   end

`ifdef UART_RX_CTRL_LAST_EN
   localparam int SIL_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

   logic             stg_valid;
   logic [7:0]       stg_data;
   logic [SIL_W-1:0] sil_cnt;
   logic             sil_hit;
   logic             going_off;

   assign sil_hit   = stg_valid && !rx_busy && (sil_cnt == SIL_W'(IDLE_TIMEOUT - 1));
   assign going_off = (state_d == ST_OFF) && (state_q != ST_OFF);
   // The staged byte leaves either because a newer byte replaces it (not the
   // end of the packet) or because the packet was closed (end of packet).
   assign fifo_push = stg_valid && (capture || sil_hit || going_off);
   assign fifo_din  = {sil_hit || going_off, stg_data};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_valid <= 1'b0;
         stg_data  <= '0;
         sil_cnt   <= '0;
      end else begin
         if (capture) begin
            stg_valid <= 1'b1;
            stg_data  <= rx_data;
         end else if (sil_hit || going_off) begin
            stg_valid <= 1'b0;
         end

         if (capture || rx_busy || !stg_valid || sil_hit) begin
            sil_cnt <= '0;
         end else begin
            sil_cnt <= sil_cnt + 1'b1;
         end
      end
   end

   assign m_last = fifo_dout[8];
`else
   // Without staging every byte goes straight in and never marks a packet end.
   logic             unused_busy;
   logic             unused_last;
   logic [31:0]      unused_idle;

   assign fifo_push   = capture;
   assign fifo_din    = {1'b0, rx_data};
   assign m_last      = 1'b0;
   assign unused_busy = rx_busy;
   assign unused_last = fifo_dout[8];
   assign unused_idle = IDLE_TIMEOUT;
`endif

   uart8_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (m_ready),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   assign m_valid = !fifo_empty;
   assign m_data  = fifo_dout[7:0];
   assign fault   = (state_q == ST_FAULT);
   assign state   = state_q;

endmodule

// File: tb/tb_uart8_rx_controller.sv
// Directed bench for uart8_rx_controller: inputs change 1 time unit after
// the rising edge, outputs are sampled then or on the falling edge.
module tb_uart8_rx_controller;
   import uart8_rx_controller_pkg::*;

   localparam int FIFO_DEPTH   = 8;
   localparam int IDLE_TIMEOUT = 480;
   localparam int ERR_LIMIT    = 3;
   localparam int CW           = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_CTRL_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n, enable, clear, rx_busy, rx_done, rx_err, m_ready;
   logic [7:0]      rx_data;
   logic            rx_en, m_valid, m_last, overflow, fault;
   logic [7:0]      m_data, err_count;
   logic [CW-1:0]   fifo_count;
   rx_state_e       state;

   int              n_vec = 0;
   int              n_err = 0;
   int              pop_cnt = 0;
   int              cyc = 0;
   int              last_cyc = 0;
   bit              mon_en = 1'b0;
   logic [8:0]      exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   uart8_rx_controller #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .ERR_LIMIT    (ERR_LIMIT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .clear      (clear),
      .rx_busy    (rx_busy),
      .rx_done    (rx_done),
      .rx_err     (rx_err),
      .rx_data    (rx_data),
      .rx_en      (rx_en),
      .m_valid    (m_valid),
      .m_last     (m_last),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .fault      (fault),
      .err_count  (err_count),
      .state      (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every stream beat must match the head of exp_q
   always @(negedge clk) begin
      if (mon_en && m_valid && m_ready) begin
         pop_cnt++;
         if (m_last) last_cyc = cyc;
         if (exp_q.size() == 0) check("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
         else                   check("sb_beat", {m_last, m_data}, exp_q.pop_front());
      end
   end

   function automatic logic [8:0] entry(input logic [7:0] d, input bit last_if_staged);
      return {LAST_EN & last_if_staged, d};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_run(input string tag);
      for (int i = 0; i < 10 && state != ST_RUN; i++) tick();
      check(tag, state, ST_RUN);
   endtask

   // One error pulse in RUN, then the two-cycle recovery.
   task automatic err_pulse(input string tag, input bit expect_fault);
      rx_err = 1'b1;
      tick();
      rx_err = 1'b0;
      check({tag, "_rec1"}, state, ST_RECOVER);
      check({tag, "_rec1_en"}, rx_en, 1'b0);
      tick();
      check({tag, "_rec2"}, state, ST_RECOVER);
      tick();
      check({tag, "_after"}, state, expect_fault ? ST_FAULT : ST_ARM);
      check({tag, "_after_en"}, rx_en, !expect_fault);
   endtask

   initial begin
      int p0;
      int cap_cyc;
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; rx_busy = 1'b0;
      rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
      repeat (3) tick();

      // reset state
      check("rst_state", state, ST_OFF);
      check("rst_rx_en", rx_en, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_m_data", m_data, 8'h00);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_fault", fault, 1'b0);
      check("rst_err_count", err_count, 8'h00);

      rst_n = 1'b1;
      tick();
      check("off_holds", state, ST_OFF);
      enable = 1'b1;
      mon_en = 1'b1;
      tick();
      check("arm", state, ST_ARM);
      check("arm_rx_en", rx_en, 1'b1);
      tick();
      check("run", state, ST_RUN);

      // two bytes back to back, consumer always ready
      m_ready = 1'b1;
      exp_q.push_back(entry(8'h55, 1'b0));
      exp_q.push_back(entry(8'hA3, 1'b1));
      send_byte(8'h55);
      if (!LAST_EN) check("first_byte_popped", pop_cnt, 1);
      rx_data = 8'hA3;
      rx_done = 1'b1;
      tick();
      cap_cyc = cyc;
      rx_done = 1'b0;
      tick();
      wait_drain("drain_two_bytes", IDLE_TIMEOUT + 40);
      if (LAST_EN) check("last_latency", last_cyc - cap_cyc, IDLE_TIMEOUT);

      // rx_done held for 16 cycles is one byte
      p0 = pop_cnt;
      exp_q.push_back(entry(8'h3C, 1'b1));
      rx_data = 8'h3C;
      rx_done = 1'b1;
      repeat (16) tick();
      rx_done = 1'b0;
      tick();
      wait_drain("drain_held_done", IDLE_TIMEOUT + 40);
      check("held_done_beats", pop_cnt - p0, 1);

      // done and error on the same edge: byte dropped, error counted
      p0 = pop_cnt;
      rx_data = 8'h77;
      rx_done = 1'b1;
      rx_err = 1'b1;
      tick();
      rx_done = 1'b0;
      rx_err = 1'b0;
      check("simul_state", state, ST_RECOVER);
      check("simul_err_count", err_count, 8'd1);
      repeat (4) tick();
      check("simul_no_push", fifo_count, 0);
      check("simul_no_beat", pop_cnt - p0, 0);
      wait_run("simul_back_run");

      // second consecutive error stays below the limit
      err_pulse("err2", 1'b0);
      check("err2_count", err_count, 8'd2);
      wait_run("err2_back_run");

      // a good byte resets the consecutive count
      exp_q.push_back(entry(8'h42, 1'b1));
      send_byte(8'h42);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_err_count", err_count, 8'd0);
      check("clear_keeps_run", state, ST_RUN);

      // three consecutive errors -> FAULT
      err_pulse("e1", 1'b0);
      wait_run("e1_run");
      err_pulse("e2", 1'b0);
      wait_run("e2_run");
      err_pulse("e3", 1'b1);
      check("fault_err_count", err_count, 8'd3);
      check("fault_flag", fault, 1'b1);
      enable = 1'b0;
      tick();
      check("fault_ignores_enable", state, ST_FAULT);
      enable = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_to_off", state, ST_OFF);
      check("clear_fault", fault, 1'b0);
      check("clear_err_count2", err_count, 8'd0);
      wait_drain("drain_0x42", IDLE_TIMEOUT + 40);
      wait_run("restart_run");

      // overflow: consumer stalled, one byte more than the FIFO holds
      m_ready = 1'b0;
      for (int i = 0; i < FIFO_DEPTH + 1 + int'(LAST_EN); i++) begin
         if (i < FIFO_DEPTH) exp_q.push_back(entry(8'h10 + 8'(i), 1'b0));
         send_byte(8'h10 + 8'(i));
      end
      if (LAST_EN) exp_q.push_back(entry(8'h10 + 8'(FIFO_DEPTH + 1), 1'b1));
      check("ovf_count", fifo_count, FIFO_DEPTH);
      check("ovf_flag", overflow, 1'b1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("ovf_cleared", overflow, 1'b0);
      check("ovf_clear_keeps_fifo", fifo_count, FIFO_DEPTH);
      m_ready = 1'b1;
      wait_drain("drain_overflow", IDLE_TIMEOUT + 60);

      // enable dropped while a byte may be staged
      exp_q.push_back(entry(8'h99, 1'b1));
      send_byte(8'h99);
      enable = 1'b0;
      tick();
      check("disable_off", state, ST_OFF);
      check("disable_rx_en", rx_en, 1'b0);
      wait_drain("drain_disable", 10);
      enable = 1'b1;
      wait_run("reenable_run");

      // reset with four bytes waiting
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
      check("pre_reset_count", fifo_count, 4 - int'(LAST_EN));
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      check("mid_reset_valid", m_valid, 1'b0);
      check("mid_reset_count", fifo_count, 0);
      check("mid_reset_data", m_data, 8'h00);
      check("mid_reset_state", state, ST_OFF);
      rst_n = 1'b1;
      m_ready = 1'b1;
      p0 = pop_cnt;
      repeat (LAST_EN ? IDLE_TIMEOUT + 20 : 20) tick();
      check("post_reset_no_beat", pop_cnt - p0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
